// File: rtl/mpi_regfile_slave.sv
// rtl/mpi_regfile_slave.sv - strobe-bus register file slave with RO status region and ack handshake
module mpi_regfile_slave #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 48,
    parameter int RO_BASE     = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clock,
    input  logic              Rst,
    inout  wire  [DATA_W-1:0] Mpi_data,
    input  logic [ADDR_W-1:0] Mpi_addr,
    input  logic              Mpi_cs_n,
    input  logic              Mpi_rw,
    output logic              Mpi_ack,
    output logic              Addr_err,
    input  logic              Stat_we,
    input  logic [ADDR_W-1:0] Stat_addr,
    input  logic [DATA_W-1:0] Stat_data,
    input  logic [ADDR_W-1:0] Core_rd_addr,
    output logic [DATA_W-1:0] Core_rd_data,
    output logic              Wr_pulse,
    output logic [ADDR_W-1:0] Wr_addr,
    output logic [DATA_W-1:0] Wr_data
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_RO    = (ADDR_W+1)'(RO_BASE);

    typedef enum logic [1:0] {
        ST_LOCKOUT,
        ST_IDLE,
        ST_CAPTURE,
        ST_ACTIVE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_rw_sync;
    logic               r_cs_d;
    logic               r_rise;
    logic               r_seen;
    logic               r_rd;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_regs [DEPTH];
    logic [DATA_W-1:0]  r_core_rd;
    logic               r_wr_pulse;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_addr_err;

    logic               w_cs_s;
    logic               w_is_rd;
    logic               w_fall;
    logic               w_rise;
    logic               w_capture;
    logic               w_ack;
    logic               w_oe;
    logic               w_mapped;
    logic               w_rw_addr;
    logic               w_bus_we;
    logic               w_bus_err;
    logic               w_stat_we;
    logic               w_core_mapped;

    // Sync flops reset to "asserted" so a strobe low at reset release never looks like a fresh fall
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_cs_sync <= '0;
            r_rw_sync <= '0;
            r_cs_d    <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], Mpi_cs_n};
            r_rw_sync <= {r_rw_sync[SYNC_STAGES-2:0], Mpi_rw};
            r_cs_d    <= w_cs_s;
            r_rise    <= w_rise;
        end
    end

    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_is_rd   = r_rw_sync[SYNC_STAGES-1];
    assign w_fall    = r_cs_d & ~w_cs_s;
    assign w_rise    = ~r_cs_d & w_cs_s;
    assign w_capture = (r_state == ST_CAPTURE);

    assign w_mapped      = ({1'b0, Mpi_addr} < LP_DEPTH);
    assign w_rw_addr     = ({1'b0, Mpi_addr} < LP_RO);
    assign w_bus_we      = w_capture & ~w_is_rd & w_rw_addr;
    assign w_bus_err     = w_capture & (~w_mapped | (~w_is_rd & ~w_rw_addr));
    assign w_stat_we     = Stat_we & ({1'b0, Stat_addr} >= LP_RO) & ({1'b0, Stat_addr} < LP_DEPTH);
    assign w_core_mapped = ({1'b0, Core_rd_addr} < LP_DEPTH);

    // FSM state register
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_LOCKOUT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs; ack only once cs_n was seen still low in ACTIVE
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_oe        = 1'b0;
        case (r_state)
            ST_LOCKOUT: if (w_cs_s) w_state_nxt = ST_IDLE;
            ST_IDLE:    if (w_fall) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = w_cs_s ? ST_IDLE : ST_ACTIVE;
            ST_ACTIVE: begin
                w_ack = r_seen | ~w_cs_s;
                w_oe  = w_ack & r_rd;
                if (r_rise) w_state_nxt = ST_IDLE;
            end
            default:    w_state_nxt = ST_LOCKOUT;
        endcase
    end

    // Holds ack through the rise-detect latency once it has been shown to the host
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_seen <= 1'b0;
        end else begin
            r_seen <= (r_state == ST_ACTIVE) & w_ack;
        end
    end

    // Register file: bus writes to RW region, core writes to RO region, never the same entry
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_bus_we) begin
                r_regs[Mpi_addr] <= Mpi_data;
            end
            if (w_stat_we) begin
                r_regs[Stat_addr] <= Stat_data;
            end
        end
    end

    // Capture direction and read data; a same-cycle core write is seen as the old value
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_rd    <= 1'b0;
            r_rdata <= '0;
        end else if (w_capture) begin
            r_rd <= w_is_rd;
            if (w_is_rd) begin
                r_rdata <= w_mapped ? r_regs[Mpi_addr] : '0;
            end
        end
    end

    // Committed-write report and address error pulse
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_wr_pulse <= w_bus_we;
            r_addr_err <= w_bus_err;
            if (w_bus_we) begin
                r_wr_addr <= Mpi_addr;
                r_wr_data <= Mpi_data;
            end
        end
    end

    // Registered core read port
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            r_core_rd <= '0;
        end else begin
            r_core_rd <= w_core_mapped ? r_regs[Core_rd_addr] : '0;
        end
    end

    assign Mpi_data     = w_oe ? r_rdata : 'z;
    assign Mpi_ack      = w_ack;
    assign Addr_err     = r_addr_err;
    assign Core_rd_data = r_core_rd;
    assign Wr_pulse     = r_wr_pulse;
    assign Wr_addr      = r_wr_addr;
    assign Wr_data      = r_wr_data;

endmodule

// File: tb/tb_mpi_regfile_slave.sv
// tb/tb_mpi_regfile_slave.sv - scoreboard bench for mpi_regfile_slave
module tb_mpi_regfile_slave;

    localparam int DEPTH = 48;
    localparam int RO    = 40;

    logic       Clock = 1'b0;
    logic       Rst;
    wire  [7:0] Mpi_data;
    logic [5:0] Mpi_addr;
    logic       Mpi_cs_n;
    logic       Mpi_rw;
    logic       Mpi_ack;
    logic       Addr_err;
    logic       Stat_we;
    logic [5:0] Stat_addr;
    logic [7:0] Stat_data;
    logic [5:0] Core_rd_addr;
    logic [7:0] Core_rd_data;
    logic       Wr_pulse;
    logic [5:0] Wr_addr;
    logic [7:0] Wr_data;

    logic       host_oe;
    logic [7:0] host_data;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_err_exp = 0;
    int         n_err_seen = 0;
    logic [7:0] model [DEPTH];
    logic [7:0] q_rd [$];
    logic [13:0] q_wr [$];
    logic [13:0] mon_e;

    assign Mpi_data = host_oe ? host_data : 8'hzz;

    always #5 Clock = ~Clock;

    mpi_regfile_slave dut (
        .Clock        (Clock),
        .Rst          (Rst),
        .Mpi_data     (Mpi_data),
        .Mpi_addr     (Mpi_addr),
        .Mpi_cs_n     (Mpi_cs_n),
        .Mpi_rw       (Mpi_rw),
        .Mpi_ack      (Mpi_ack),
        .Addr_err     (Addr_err),
        .Stat_we      (Stat_we),
        .Stat_addr    (Stat_addr),
        .Stat_data    (Stat_data),
        .Core_rd_addr (Core_rd_addr),
        .Core_rd_data (Core_rd_data),
        .Wr_pulse     (Wr_pulse),
        .Wr_addr      (Wr_addr),
        .Wr_data      (Wr_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (Addr_err === 1'b1) n_err_seen++;
        if (Wr_pulse === 1'b1) begin
            if (q_wr.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = q_wr.pop_front();
                check("wr_addr", 32'(Wr_addr), 32'(mon_e[13:8]));
                check("wr_data", 32'(Wr_data), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic host_write(input logic [5:0] a, input logic [7:0] d, input int low, input bit exp_ack);
        bit saw_ack;
        saw_ack = 1'b0;
        @(negedge Clock);
        Mpi_addr  = a;
        Mpi_rw    = 1'b0;
        host_data = d;
        host_oe   = 1'b1;
        repeat (3) @(negedge Clock);
        if (int'(a) < RO) begin
            q_wr.push_back({a, d});
            model[a] = d;
        end else begin
            n_err_exp++;
        end
        Mpi_cs_n = 1'b0;
        repeat (low) begin
            @(negedge Clock);
            saw_ack = saw_ack | (Mpi_ack === 1'b1);
        end
        Mpi_cs_n = 1'b1;
        repeat (6) begin
            @(negedge Clock);
            saw_ack = saw_ack | (Mpi_ack === 1'b1);
        end
        host_oe = 1'b0;
        check($sformatf("wr_ack_%0h", a), 32'(saw_ack), 32'(exp_ack));
    endtask

    task automatic host_read(input logic [5:0] a, input int low, input bit exp_ack);
        logic [7:0] ev;
        logic [7:0] got;
        bit         saw_ack;
        bit         saw_drv;
        saw_ack = 1'b0;
        saw_drv = 1'b0;
        ev = (int'(a) < DEPTH) ? model[a] : 8'h00;
        if (int'(a) >= DEPTH) n_err_exp++;
        @(negedge Clock);
        Mpi_addr = a;
        Mpi_rw   = 1'b1;
        host_oe  = 1'b0;
        repeat (3) @(negedge Clock);
        if (exp_ack) q_rd.push_back(ev);
        Mpi_cs_n = 1'b0;
        for (int i = 1; i <= low; i++) begin
            @(negedge Clock);
            if (exp_ack && i == 3) check("ack_early", 32'(Mpi_ack), 32'd0);
            if (exp_ack && i == 4) check("ack_on", 32'(Mpi_ack), 32'd1);
            saw_ack = saw_ack | (Mpi_ack === 1'b1);
            saw_drv = saw_drv | (Mpi_data === ev);
        end
        got = Mpi_data;
        if (exp_ack) check($sformatf("rd_data_%0h", a), 32'(got), 32'(q_rd.pop_front()));
        Mpi_cs_n = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(negedge Clock);
            if (exp_ack && j == 3) begin
                check("rd_hold_ack", 32'(Mpi_ack), 32'd1);
                check("rd_hold_data", 32'(Mpi_data), 32'(ev));
            end
            if (exp_ack && j == 4) begin
                check("rd_release_ack", 32'(Mpi_ack), 32'd0);
                if (ev != 8'h00) check("rd_release_hiz", 32'(Mpi_data === ev), 32'd0);
            end
            saw_ack = saw_ack | (Mpi_ack === 1'b1);
            saw_drv = saw_drv | (Mpi_data === ev);
        end
        if (!exp_ack) begin
            check("runt_rd_ack", 32'(saw_ack), 32'd0);
            check("runt_rd_drv", 32'(saw_drv), 32'd0);
        end
    endtask

    task automatic stat_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge Clock);
        Stat_we   = 1'b1;
        Stat_addr = a;
        Stat_data = d;
        @(negedge Clock);
        Stat_we = 1'b0;
        if (int'(a) >= RO && int'(a) < DEPTH) model[a] = d;
    endtask

    task automatic core_check(input logic [5:0] a);
        @(negedge Clock);
        Core_rd_addr = a;
        @(negedge Clock);
        check($sformatf("core_rd_%0h", a), 32'(Core_rd_data), 32'((int'(a) < DEPTH) ? model[a] : 8'h00));
    endtask

    initial begin
        bit saw_ack;
        Rst          = 1'b1;
        Mpi_cs_n     = 1'b1;
        Mpi_rw       = 1'b1;
        Mpi_addr     = '0;
        host_oe      = 1'b0;
        host_data    = '0;
        Stat_we      = 1'b0;
        Stat_addr    = '0;
        Stat_data    = '0;
        Core_rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

        repeat (2) @(negedge Clock);
        check("rst_ack", 32'(Mpi_ack), 32'd0);
        check("rst_addr_err", 32'(Addr_err), 32'd0);
        check("rst_wr_pulse", 32'(Wr_pulse), 32'd0);
        check("rst_wr_addr", 32'(Wr_addr), 32'd0);
        check("rst_wr_data", 32'(Wr_data), 32'd0);
        check("rst_core_rd", 32'(Core_rd_data), 32'd0);
        check("rst_hiz", 32'($isunknown(Mpi_data) || Mpi_data == 8'h00), 32'd1);
        Rst = 1'b0;
        repeat (5) @(negedge Clock);

        host_write(6'h05, 8'hA5, 6, 1'b1);
        host_read(6'h05, 6, 1'b1);

        for (int a = 47; a >= 0; a--) host_write(6'(a), 8'(a * 7 + 3), 6, 1'b1);
        for (int a = 0; a < DEPTH; a++) host_read(6'(a), 6, 1'b1);
        check("err_cnt_fill", 32'(n_err_seen), 32'(n_err_exp));

        stat_write(6'h2A, 8'h3C);
        host_write(6'h2A, 8'h11, 6, 1'b1);
        host_read(6'h2A, 6, 1'b1);
        stat_write(6'h03, 8'hEE);
        core_check(6'h03);
        core_check(6'h2A);
        check("err_cnt_ro", 32'(n_err_seen), 32'(n_err_exp));

        host_write(6'h30, 8'h99, 6, 1'b1);
        host_write(6'h3F, 8'h66, 6, 1'b1);
        host_read(6'h30, 6, 1'b1);
        host_read(6'h3F, 6, 1'b1);
        check("err_cnt_unmapped", 32'(n_err_seen), 32'(n_err_exp));
        for (int a = 0; a < 64; a++) core_check(6'(a));

        host_write(6'h01, 8'h77, 2, 1'b0);
        core_check(6'h01);
        host_read(6'h01, 2, 1'b0);
        check("wr_q_empty", 32'(q_wr.size()), 32'd0);

        @(negedge Clock);
        Mpi_addr = 6'h05;
        Mpi_rw   = 1'b1;
        repeat (3) @(negedge Clock);
        Mpi_cs_n = 1'b0;
        repeat (6) @(negedge Clock);
        check("pre_rst_ack", 32'(Mpi_ack), 32'd1);
        check("pre_rst_data", 32'(Mpi_data), 32'(model[5]));
        Rst = 1'b1;
        #1;
        check("mid_rst_ack", 32'(Mpi_ack), 32'd0);
        check("mid_rst_hiz", 32'(Mpi_data === model[5]), 32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        @(negedge Clock);
        Rst = 1'b0;
        saw_ack = 1'b0;
        repeat (10) begin
            @(negedge Clock);
            saw_ack = saw_ack | (Mpi_ack === 1'b1);
        end
        check("lockout_ack", 32'(saw_ack), 32'd0);
        Mpi_cs_n = 1'b1;
        repeat (6) @(negedge Clock);
        check("post_rst_wr_addr", 32'(Wr_addr), 32'd0);
        host_read(6'h05, 6, 1'b1);
        core_check(6'h05);
        core_check(6'h2A);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
